// File: rtl/hba_quad_sampler_pkg.sv
// Shared definitions for the hba_quad snapshot master: register map, ctrl
// enable mask, sequencer states and the fixed six-step transfer table.
package hba_quad_sampler_pkg;

    localparam logic [7:0] QUAD_REG_CTRL  = 8'd0;
    localparam logic [7:0] QUAD_REG_Q0_LO = 8'd1;
    localparam logic [7:0] QUAD_REG_Q0_HI = 8'd2;
    localparam logic [7:0] QUAD_REG_Q1_LO = 8'd3;
    localparam logic [7:0] QUAD_REG_Q1_HI = 8'd4;

    localparam logic [7:0] CTRL_EN_MASK = 8'h03;

    localparam logic [2:0] STEP_LAST = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_GAP,
        ST_DONE
    } state_t;

    // Steps 0 and 5 both target the ctrl register (freeze / re-enable).
    function automatic logic [7:0] stepReg(input logic [2:0] step);
        case (step)
            3'd1:    stepReg = QUAD_REG_Q0_LO;
            3'd2:    stepReg = QUAD_REG_Q0_HI;
            3'd3:    stepReg = QUAD_REG_Q1_LO;
            3'd4:    stepReg = QUAD_REG_Q1_HI;
            default: stepReg = QUAD_REG_CTRL;
        endcase
    endfunction

    function automatic logic stepIsRead(input logic [2:0] step);
        return (step >= 3'd1) && (step <= 3'd4);
    endfunction

endpackage

// File: rtl/hba_quad_sampler_xfer.sv
// Single-transfer HBA master engine: holds select/abus/rnw/dbus stable from
// start until the slave acks or the wait limit expires.
module hba_master_xfer
    import hba_quad_sampler_pkg::*;
#(
    parameter int DBUS_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_rnw,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DBUS_WIDTH-1:0] i_wdata,
    input  logic [DBUS_WIDTH-1:0] i_dbus,
    input  logic                  i_xferack,
    output logic                  o_select,
    output logic                  o_rnw,
    output logic [ADDR_WIDTH-1:0] o_abus,
    output logic [DBUS_WIDTH-1:0] o_dbus,
    output logic                  o_done,
    output logic [DBUS_WIDTH-1:0] o_rdata,
    output logic                  o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                  r_active;
    logic                  r_rnw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DBUS_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_timeout;

    // Fires on the TIMEOUT_CYCLES-th selected cycle that still has no ack.
    assign w_timeout = r_active && !i_xferack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_rnw    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_rnw    <= i_rnw;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_cnt    <= '0;
        end else if (r_active && (i_xferack || w_timeout)) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_select  = r_active;
    assign o_rnw     = r_active && r_rnw;
    assign o_abus    = r_active ? r_addr : '0;
    assign o_dbus    = (r_active && !r_rnw) ? r_wdata : '0;
    assign o_done    = r_active && i_xferack;
    assign o_rdata   = i_dbus;
    assign o_timeout = w_timeout;

endmodule

// File: rtl/hba_quad_sampler.sv
// HBA bus master that freezes hba_quad, reads both 16-bit encoder counts,
// re-enables it and publishes the coherent pair on a valid/ready port.
module hba_quad_sampler
    import hba_quad_sampler_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int QUAD_PERIPH_ADDR  = 0,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic                  trigger,
    input  logic [7:0]            ctrl_run,
    output logic                  master_req,
    input  logic                  master_grant,
    output logic                  master_select,
    output logic                  master_rnw,
    output logic [ADDR_WIDTH-1:0] master_abus,
    output logic [DBUS_WIDTH-1:0] master_dbus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    input  logic                  hba_xferack,
    output logic [15:0]           snap_left,
    output logic [15:0]           snap_right,
    output logic                  snap_valid,
    input  logic                  snap_ready,
    output logic                  overrun,
    output logic                  bus_err,
    input  logic                  clr_status,
    output logic                  busy
);

    state_t                r_state;
    state_t                w_stateNext;
    logic [2:0]            r_step;
    logic                  r_seqErr;
    logic                  r_pend;
    logic [15:0]           r_capLeft;
    logic [15:0]           r_capRight;
    logic [15:0]           r_snapLeft;
    logic [15:0]           r_snapRight;
    logic                  r_snapValid;
    logic                  r_overrun;
    logic                  r_busErr;

    logic                  w_go;
    logic                  w_start;
    logic                  w_done;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DBUS_WIDTH-1:0] w_wdata;
    logic [DBUS_WIDTH-1:0] w_rdata;

    assign w_go    = (r_state == ST_IDLE) && !r_snapValid && (trigger || r_pend);
    assign w_addr  = {PERIPH_ADDR_WIDTH'(QUAD_PERIPH_ADDR), REG_ADDR_WIDTH'(stepReg(r_step))};
    assign w_wdata = (r_step == 3'd0) ? DBUS_WIDTH'(ctrl_run & ~CTRL_EN_MASK)
                                      : DBUS_WIDTH'(ctrl_run);

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A failed sequence still finishes with the re-enable write but publishes nothing.
    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_stateNext = ST_REQ;
                end
            end
            ST_REQ: begin
                if (master_grant) begin
                    w_stateNext = ST_XFER;
                    w_start     = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_timeout) begin
                    w_stateNext = (r_step == STEP_LAST) ? ST_IDLE : ST_GAP;
                end else if (w_done) begin
                    if (r_step != STEP_LAST) begin
                        w_stateNext = ST_GAP;
                    end else begin
                        w_stateNext = r_seqErr ? ST_IDLE : ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                w_stateNext = ST_XFER;
                w_start     = 1'b1;
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_step      <= '0;
            r_seqErr    <= 1'b0;
            r_pend      <= 1'b0;
            r_capLeft   <= '0;
            r_capRight  <= '0;
            r_snapLeft  <= '0;
            r_snapRight <= '0;
            r_snapValid <= 1'b0;
            r_overrun   <= 1'b0;
            r_busErr    <= 1'b0;
        end else begin
            if (w_go) begin
                r_step   <= '0;
                r_seqErr <= 1'b0;
            end else if (r_state == ST_XFER) begin
                if (w_timeout) begin
                    r_seqErr <= 1'b1;
                    r_step   <= STEP_LAST;
                end else if (w_done && (r_step != STEP_LAST)) begin
                    r_step <= r_step + 3'd1;
                end
            end

            if ((r_state == ST_XFER) && w_done) begin
                case (r_step)
                    3'd1:    r_capLeft[7:0]   <= w_rdata[7:0];
                    3'd2:    r_capLeft[15:8]  <= w_rdata[7:0];
                    3'd3:    r_capRight[7:0]  <= w_rdata[7:0];
                    3'd4:    r_capRight[15:8] <= w_rdata[7:0];
                    default: ;
                endcase
            end

            // A trigger that coincides with consuming the latch re-arms it.
            if (w_go) begin
                r_pend <= trigger && r_pend;
            end else if (trigger) begin
                r_pend <= 1'b1;
            end

            if (trigger && r_pend && !w_go) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end

            if (w_timeout) begin
                r_busErr <= 1'b1;
            end else if (clr_status) begin
                r_busErr <= 1'b0;
            end

            if (r_state == ST_DONE) begin
                r_snapLeft  <= r_capLeft;
                r_snapRight <= r_capRight;
                r_snapValid <= 1'b1;
            end else if (r_snapValid && snap_ready) begin
                r_snapValid <= 1'b0;
            end
        end
    end

    hba_master_xfer #(
        .DBUS_WIDTH     (DBUS_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .i_clk     (hba_clk),
        .i_rst_n   (hba_reset_n),
        .i_start   (w_start),
        .i_rnw     (stepIsRead(r_step)),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_dbus    (hba_dbus),
        .i_xferack (hba_xferack),
        .o_select  (master_select),
        .o_rnw     (master_rnw),
        .o_abus    (master_abus),
        .o_dbus    (master_dbus),
        .o_done    (w_done),
        .o_rdata   (w_rdata),
        .o_timeout (w_timeout)
    );

    assign master_req = (r_state == ST_REQ) || (r_state == ST_XFER) || (r_state == ST_GAP);
    assign busy       = (r_state != ST_IDLE);
    assign snap_left  = r_snapLeft;
    assign snap_right = r_snapRight;
    assign snap_valid = r_snapValid;
    assign overrun    = r_overrun;
    assign bus_err    = r_busErr;

endmodule

// File: tb/tb_hba_quad_sampler.sv
// Scoreboard bench for hba_quad_sampler: a behavioural arbiter and hba_quad
// slave answer the bus, expected transfers and snapshots are queued up front.
module tb_hba_quad_sampler;

    localparam int TIMEOUT = 255;

    typedef struct {
        logic        rnw;
        logic [11:0] abus;
        logic [7:0]  dbus;
    } xfer_t;

    logic        hba_clk = 1'b0;
    logic        hba_reset_n = 1'b0;
    logic        trigger = 1'b0;
    logic [7:0]  ctrl_run = 8'h00;
    logic        master_req;
    logic        master_grant = 1'b0;
    logic        master_select;
    logic        master_rnw;
    logic [11:0] master_abus;
    logic [7:0]  master_dbus;
    logic [7:0]  hba_dbus = 8'h00;
    logic        hba_xferack = 1'b0;
    logic [15:0] snap_left;
    logic [15:0] snap_right;
    logic        snap_valid;
    logic        snap_ready = 1'b0;
    logic        overrun;
    logic        bus_err;
    logic        clr_status;
    logic        busy;

    logic        clrMain = 1'b0;
    logic        clrSlave = 1'b0;
    assign clr_status = clrMain | clrSlave;

    int          nChecks = 0;
    int          nBad = 0;

    xfer_t       expXfers[$];
    logic [31:0] expSnaps[$];
    logic [7:0]  slaveRegs[0:7];

    // slave / arbiter knobs driven by the main sequence
    bit          randomAck = 1'b0;
    int          fixedDelay = 0;
    bit          noAckEn = 1'b0;
    logic [7:0]  noAckReg = 8'h00;
    bit          clrOnTimeout = 1'b0;
    int          grantDelay = 3;

    // slave observations
    bit          inXfer = 1'b0;
    bit          ackedPrev = 1'b0;
    int          waitCnt = 0;
    int          curDelay = 0;
    int          selCycles = 0;
    int          lastTimeoutLen = 0;
    logic        busErrAtDrop = 1'b0;
    logic [11:0] refAbus;
    logic        refRnw;
    logic [7:0]  refDbus;
    xfer_t       slvExp;
    int          reqCnt = 0;
    logic [31:0] snapExp;

    hba_quad_sampler dut (
        .hba_clk       (hba_clk),
        .hba_reset_n   (hba_reset_n),
        .trigger       (trigger),
        .ctrl_run      (ctrl_run),
        .master_req    (master_req),
        .master_grant  (master_grant),
        .master_select (master_select),
        .master_rnw    (master_rnw),
        .master_abus   (master_abus),
        .master_dbus   (master_dbus),
        .hba_dbus      (hba_dbus),
        .hba_xferack   (hba_xferack),
        .snap_left     (snap_left),
        .snap_right    (snap_right),
        .snap_valid    (snap_valid),
        .snap_ready    (snap_ready),
        .overrun       (overrun),
        .bus_err       (bus_err),
        .clr_status    (clr_status),
        .busy          (busy)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Queue the transfers and snapshot this trigger should produce, then pulse it.
    task automatic applyStimulus(input logic [7:0] ctrl, input int stuckStep, input bit willRun);
        xfer_t t;
        ctrl_run = ctrl;
        if (willRun) begin
            for (int s = 0; s < 6; s++) begin
                if (stuckStep >= 0 && s >= stuckStep && s < 5) continue;
                t.rnw  = (s >= 1 && s <= 4);
                t.abus = (s == 0 || s == 5) ? 12'h000 : 12'(s);
                t.dbus = (s == 0) ? (ctrl & 8'hFC) : ((s == 5) ? ctrl : 8'h00);
                expXfers.push_back(t);
            end
            if (stuckStep < 0)
                expSnaps.push_back({slaveRegs[2], slaveRegs[1], slaveRegs[4], slaveRegs[3]});
        end
        trigger = 1'b1;
        @(negedge hba_clk);
        trigger = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            @(negedge hba_clk);
            n++;
        end
        if (busy) checkOutput("idleWait", busy, 0);
    endtask

    task automatic pulseClear();
        clrMain = 1'b1;
        @(negedge hba_clk);
        clrMain = 1'b0;
    endtask

    // Arbiter: grant after grantDelay cycles of request, held while requested.
    always @(negedge hba_clk) begin
        if (master_req) begin
            reqCnt++;
            master_grant = (reqCnt >= grantDelay);
        end else begin
            reqCnt = 0;
            master_grant = 1'b0;
        end
    end

    // hba_quad slave model with programmable ack latency and stability checks.
    always @(negedge hba_clk) begin
        hba_xferack = 1'b0;
        hba_dbus    = 8'h00;
        clrSlave    = 1'b0;
        if (!hba_reset_n) begin
            inXfer    = 1'b0;
            ackedPrev = 1'b0;
        end else if (ackedPrev) begin
            checkOutput("gapAfterAck", master_select, 0);
            ackedPrev = 1'b0;
            inXfer    = 1'b0;
        end else if (master_select) begin
            if (!inXfer) begin
                inXfer    = 1'b1;
                waitCnt   = 0;
                selCycles = 0;
                refAbus   = master_abus;
                refRnw    = master_rnw;
                refDbus   = master_dbus;
                curDelay  = randomAck ? int'($urandom_range(0, 20)) : fixedDelay;
            end else begin
                checkOutput("abusStable", master_abus, refAbus);
                checkOutput("rnwStable", master_rnw, refRnw);
                checkOutput("dbusStable", master_dbus, refDbus);
            end
            selCycles++;
            if (noAckEn && master_abus[7:0] == noAckReg) begin
                if (clrOnTimeout && selCycles == TIMEOUT) clrSlave = 1'b1;
            end else if (waitCnt >= curDelay) begin
                hba_xferack = 1'b1;
                if (master_rnw) hba_dbus = slaveRegs[master_abus[2:0]];
                ackedPrev = 1'b1;
                if (expXfers.size() == 0) begin
                    checkOutput("unexpectedXfer", 1, 0);
                end else begin
                    slvExp = expXfers.pop_front();
                    checkOutput("xferRnw", master_rnw, slvExp.rnw);
                    checkOutput("xferAbus", master_abus, slvExp.abus);
                    checkOutput("xferDbus", master_dbus, slvExp.dbus);
                end
            end else begin
                waitCnt++;
            end
        end else if (inXfer) begin
            lastTimeoutLen = selCycles;
            busErrAtDrop   = bus_err;
            inXfer         = 1'b0;
        end
    end

    // Snapshot consumer side of the scoreboard.
    always @(negedge hba_clk) begin
        if (hba_reset_n && snap_valid && snap_ready) begin
            if (expSnaps.size() == 0) begin
                checkOutput("unexpectedSnap", 1, 0);
            end else begin
                snapExp = expSnaps.pop_front();
                checkOutput("snapLeft", snap_left, snapExp[31:16]);
                checkOutput("snapRight", snap_right, snapExp[15:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) slaveRegs[i] = 8'h00;

        // reset state
        repeat (3) @(negedge hba_clk);
        checkOutput("rstReq", master_req, 0);
        checkOutput("rstSelect", master_select, 0);
        checkOutput("rstRnw", master_rnw, 0);
        checkOutput("rstAbus", master_abus, 0);
        checkOutput("rstDbus", master_dbus, 0);
        checkOutput("rstLeft", snap_left, 0);
        checkOutput("rstRight", snap_right, 0);
        checkOutput("rstValid", snap_valid, 0);
        checkOutput("rstOverrun", overrun, 0);
        checkOutput("rstBusErr", bus_err, 0);
        checkOutput("rstBusy", busy, 0);
        hba_reset_n = 1'b1;
        repeat (2) @(negedge hba_clk);

        // basic snapshot of 0x1234 / 0xBEEF
        $display("[TB] basic sequence");
        slaveRegs[1] = 8'h34; slaveRegs[2] = 8'h12;
        slaveRegs[3] = 8'hEF; slaveRegs[4] = 8'hBE;
        snap_ready = 1'b0;
        applyStimulus(8'h07, -1, 1'b1);
        waitIdle(500);
        checkOutput("basicValid", snap_valid, 1);
        checkOutput("basicLeft", snap_left, 16'h1234);
        checkOutput("basicRight", snap_right, 16'hBEEF);
        checkOutput("basicReqDrop", master_req, 0);

        // two triggers while the snapshot is unconsumed
        $display("[TB] pending latch and overrun");
        slaveRegs[1] = 8'h78; slaveRegs[2] = 8'h56;
        slaveRegs[3] = 8'hCD; slaveRegs[4] = 8'hAB;
        applyStimulus(8'h07, -1, 1'b1);
        checkOutput("latchNoOverrun", overrun, 0);
        checkOutput("latchHoldsIdle", busy, 0);
        applyStimulus(8'h07, -1, 1'b0);
        checkOutput("overrunSet", overrun, 1);
        repeat (5) @(negedge hba_clk);
        checkOutput("stillIdle", busy, 0);
        snap_ready = 1'b1;
        repeat (3) @(negedge hba_clk);
        checkOutput("latchedRuns", busy, 1);
        waitIdle(500);
        repeat (20) @(negedge hba_clk);
        checkOutput("oneSeqOnly", busy, 0);
        checkOutput("xferQAfterOverrun", expXfers.size(), 0);
        checkOutput("snapQAfterOverrun", expSnaps.size(), 0);
        pulseClear();
        checkOutput("overrunCleared", overrun, 0);

        // slave never acks the Q0_HI read
        $display("[TB] timeout on step 2");
        noAckEn = 1'b1; noAckReg = 8'd2;
        applyStimulus(8'h07, 2, 1'b1);
        waitIdle(1000);
        repeat (3) @(negedge hba_clk);
        noAckEn = 1'b0;
        checkOutput("timeoutBusErr", bus_err, 1);
        checkOutput("timeoutLen", lastTimeoutLen, TIMEOUT);
        checkOutput("busErrAtDrop", busErrAtDrop, 1);
        checkOutput("timeoutNoValid", snap_valid, 0);
        checkOutput("xferQAfterTimeout", expXfers.size(), 0);
        pulseClear();
        checkOutput("busErrCleared", bus_err, 0);

        // asynchronous reset while step 3 is on the bus
        $display("[TB] reset mid-sequence");
        fixedDelay = 3;
        applyStimulus(8'h05, -1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge hba_clk);
            if (master_select && master_abus == 12'h003) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("step3Seen", found, 1);
        hba_reset_n = 1'b0;
        #1;
        checkOutput("arstSelect", master_select, 0);
        checkOutput("arstReq", master_req, 0);
        checkOutput("arstValid", snap_valid, 0);
        checkOutput("arstBusy", busy, 0);
        expXfers.delete();
        expSnaps.delete();
        repeat (2) @(negedge hba_clk);
        hba_reset_n = 1'b1;
        repeat (3) @(negedge hba_clk);
        checkOutput("postRstBusy", busy, 0);
        checkOutput("postRstReq", master_req, 0);
        fixedDelay = 0;

        // randomized ack latency per transfer
        $display("[TB] random ack delays");
        randomAck = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int r = 1; r <= 4; r++) slaveRegs[r] = 8'($urandom_range(0, 255));
            grantDelay = int'($urandom_range(1, 4));
            applyStimulus(8'($urandom_range(0, 255)), -1, 1'b1);
            waitIdle(1000);
            repeat (3) @(negedge hba_clk);
        end
        randomAck = 1'b0;
        grantDelay = 3;
        checkOutput("xferQAfterRandom", expXfers.size(), 0);
        checkOutput("snapQAfterRandom", expSnaps.size(), 0);

        // clear request in the very cycle the timeout fires
        $display("[TB] clear coincident with timeout");
        checkOutput("busErrBefore", bus_err, 0);
        noAckEn = 1'b1; noAckReg = 8'd1; clrOnTimeout = 1'b1;
        applyStimulus(8'h3B, 1, 1'b1);
        waitIdle(1000);
        repeat (3) @(negedge hba_clk);
        noAckEn = 1'b0; clrOnTimeout = 1'b0;
        checkOutput("clrVsErrLen", lastTimeoutLen, TIMEOUT);
        checkOutput("clrVsErrBusErr", bus_err, 1);
        checkOutput("xferQFinal", expXfers.size(), 0);
        checkOutput("snapQFinal", expSnaps.size(), 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
